// File: rtl/tri_err_capture.sv
// Error capture block: per-lane active-low errors, first-error latch,
// sticky accumulation, saturating event counter and a report handshake.
module tri_err_capture #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [0:WIDTH-1]     err_in_b,
    input  logic [0:WIDTH-1]     mask,
    input  logic                 clr,
    input  logic                 rpt_ack,
    output logic                 rpt_req,
    output logic [0:WIDTH-1]     first_err,
    output logic [0:WIDTH-1]     err_sticky,
    output logic                 err_any,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [1:0]           state_q, state_d;
    logic                 rpt_req_q, rpt_req_d;
    logic [0:WIDTH-1]     first_err_q, first_err_d;
    logic [0:WIDTH-1]     err_sticky_q, err_sticky_d;
    logic                 err_any_q, err_any_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    // Errors are qualified straight off the pins; no input register.
    logic [0:WIDTH-1] err_act;
    logic             act_any;
    logic [0:WIDTH-1] lowest;

    assign err_act = ~err_in_b & ~mask;
    assign act_any = |err_act;

    // One-hot of the lowest-index active lane (lane 0 wins).
    always_comb begin
        lowest = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (err_act[i]) begin
                lowest    = '0;
                lowest[i] = 1'b1;
            end
        end
    end

    // Report FSM and first-error latch.
    always_comb begin
        state_d     = state_q;
        first_err_d = first_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (act_any) begin
                    state_d     = S_REQ;
                    first_err_d = lowest;
                end else if (clr) begin
                    first_err_d = '0;
                end
            end
            S_REQ: begin
                if (rpt_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (clr) begin
                    if (act_any) begin
                        state_d     = S_REQ;
                        first_err_d = lowest;
                    end else begin
                        state_d     = S_IDLE;
                        first_err_d = '0;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                first_err_d = '0;
            end
        endcase
        rpt_req_d = (state_d == S_REQ);
    end

    // Sticky lanes and saturating event counter; clr restarts both
    // from the current cycle's errors.
    always_comb begin
        err_sticky_d = err_sticky_q | err_act;
        err_cnt_d    = err_cnt_q;
        if (act_any && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
        if (clr) begin
            err_sticky_d = err_act;
            err_cnt_d    = act_any ? CNT_WIDTH'(1) : '0;
        end
        err_any_d = |err_sticky_d;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rpt_req_q    <= 1'b0;
            first_err_q  <= '0;
            err_sticky_q <= '0;
            err_any_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            rpt_req_q    <= rpt_req_d;
            first_err_q  <= first_err_d;
            err_sticky_q <= err_sticky_d;
            err_any_q    <= err_any_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign rpt_req    = rpt_req_q;
    assign first_err  = first_err_q;
    assign err_sticky = err_sticky_q;
    assign err_any    = err_any_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_tri_err_capture.sv
// Bench for tri_err_capture: scoreboard of expected outputs per
// cycle plus fixed-value checks of the reference scenarios.
module tb_tri_err_capture;

    logic       clk;
    logic       rst_n;
    logic [0:3] err_in_b;
    logic [0:3] mask;
    logic       clr;
    logic       rpt_ack;
    logic       rpt_req;
    logic [0:3] first_err;
    logic [0:3] err_sticky;
    logic       err_any;
    logic [2:0] err_cnt;

    int n_vec;
    int n_bad;

    typedef struct {
        logic       req;
        logic [0:3] first;
        logic [0:3] sticky;
        logic       any;
        logic [2:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    // reference model state: 0 idle, 1 req, 2 done
    int         m_st;
    logic [0:3] m_first;
    logic [0:3] m_sticky;
    logic [2:0] m_cnt;

    tri_err_capture #(.WIDTH(4), .CNT_WIDTH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .err_in_b   (err_in_b),
        .mask       (mask),
        .clr        (clr),
        .rpt_ack    (rpt_ack),
        .rpt_req    (rpt_req),
        .first_err  (first_err),
        .err_sticky (err_sticky),
        .err_any    (err_any),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st     = 0;
        m_first  = '0;
        m_sticky = '0;
        m_cnt    = '0;
    endtask

    task automatic model_step(input logic [0:3] eb, input logic [0:3] mk,
                              input logic c, input logic a);
        logic [0:3] act;
        logic [0:3] lo;
        act = ~eb & ~mk;
        lo  = '0;
        for (int i = 0; i < 4; i++) begin
            if (act[i] && lo == 4'b0000) lo[i] = 1'b1;
        end
        if (m_st == 0) begin
            if (act != 0) begin
                m_st = 1;
                m_first = lo;
            end
        end else if (m_st == 1) begin
            if (a) m_st = 2;
        end else begin
            if (c) begin
                m_st    = (act != 0) ? 1 : 0;
                m_first = lo;
            end
        end
        if (c) begin
            m_sticky = act;
            m_cnt    = (act != 0) ? 3'd1 : 3'd0;
        end else begin
            m_sticky = m_sticky | act;
            if (act != 0 && m_cnt != 3'd7) m_cnt = m_cnt + 3'd1;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.req    = (m_st == 1);
        e.first  = m_first;
        e.sticky = m_sticky;
        e.any    = (m_sticky != 0);
        e.cnt    = m_cnt;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_req"}, rpt_req, e.req);
        chk({tag, "_first"}, first_err, e.first);
        chk({tag, "_sticky"}, err_sticky, e.sticky);
        chk({tag, "_any"}, err_any, e.any);
        chk({tag, "_cnt"}, err_cnt, e.cnt);
    endtask

    task automatic cyc(input string tag, input logic [0:3] eb,
                       input logic [0:3] mk, input logic c, input logic a);
        @(negedge clk);
        err_in_b = eb;
        mask     = mk;
        clr      = c;
        rpt_ack  = a;
        model_step(eb, mk, c, a);
        push_exp();
        @(posedge clk);
        #1;
        pop_cmp(tag);
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        err_in_b = 4'b1111;
        mask     = 4'b0000;
        clr      = 1'b0;
        rpt_ack  = 1'b0;
        model_reset();
        #22;
        chk("rst_req", rpt_req, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // lane 1 error, held report, then ack
        cyc("v30a", 4'b1011, 4'b0000, 0, 0);
        chk("v30_req", rpt_req, 1);
        chk("v30_first", first_err, 4'b0100);
        chk("v30_sticky", err_sticky, 4'b0100);
        chk("v30_cnt", err_cnt, 1);
        cyc("v30b", 4'b1111, 4'b0000, 0, 0);
        cyc("v30c", 4'b1111, 4'b0000, 0, 0);
        chk("v30_hold", rpt_req, 1);
        cyc("v30d", 4'b1111, 4'b0000, 0, 1);
        chk("v30_done", rpt_req, 0);
        chk("v30_frz", first_err, 4'b0100);
        cyc("v30e", 4'b1111, 4'b0000, 0, 1);
        cyc("clr1", 4'b1111, 4'b0000, 1, 0);
        chk("clr1_first", first_err, 0);
        chk("clr1_any", err_any, 0);

        // two lanes at once; lane 0 wins, count +1 only
        cyc("v31", 4'b0110, 4'b0000, 0, 0);
        chk("v31_first", first_err, 4'b1000);
        chk("v31_sticky", err_sticky, 4'b1001);
        chk("v31_cnt", err_cnt, 1);
        cyc("v31a", 4'b1111, 4'b0000, 0, 1);
        cyc("clr2", 4'b1111, 4'b0000, 1, 0);

        // lane 3 held ten cycles, saturates at 7
        for (int i = 0; i < 10; i++) begin
            cyc("v32", 4'b1110, 4'b0000, 0, (i == 4));
        end
        chk("v32_sat", err_cnt, 7);
        chk("v32_state", rpt_req, 0);

        // clr in done with coincident lane 3 error
        cyc("v34", 4'b1110, 4'b0000, 1, 0);
        chk("v34_req", rpt_req, 1);
        chk("v34_first", first_err, 4'b0001);
        chk("v34_sticky", err_sticky, 4'b0001);
        chk("v34_cnt", err_cnt, 1);

        // clr in req with ack: counters clear, ack still honoured
        cyc("v24", 4'b1111, 4'b0000, 1, 1);
        chk("v24_req", rpt_req, 0);
        chk("v24_first", first_err, 4'b0001);
        chk("v24_cnt", err_cnt, 0);
        cyc("clr3", 4'b1111, 4'b0000, 1, 0);

        // masked lane 2 error is invisible
        cyc("v33", 4'b1101, 4'b0010, 0, 0);
        chk("v33_req", rpt_req, 0);
        chk("v33_sticky", err_sticky, 0);
        chk("v33_cnt", err_cnt, 0);
        cyc("v33b", 4'b1101, 4'b0010, 0, 1);

        // asynchronous reset while in req
        cyc("v35a", 4'b1101, 4'b0000, 0, 0);
        chk("v35_inreq", rpt_req, 1);
        @(negedge clk);
        err_in_b = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("v35_req", rpt_req, 0);
        chk("v35_first", first_err, 0);
        chk("v35_sticky", err_sticky, 0);
        chk("v35_any", err_any, 0);
        chk("v35_cnt", err_cnt, 0);
        model_reset();
        rpt_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("v35b", 4'b1111, 4'b0000, 0, 1);
        chk("v35_noack", rpt_req, 0);
        // first edge after release sees errors normally
        cyc("v29", 4'b0111, 4'b0000, 0, 0);
        chk("v29_first", first_err, 4'b1000);

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            cyc("rnd", 4'($urandom), 4'($urandom) & 4'($urandom),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
